// File: rtl/mod_retire_wb.sv
`default_nettype none
// ============================================================================
// Module      : mod_retire_wb
// Description : Writeback/retire stage. Buffers execute results in an
//               in-order queue, commits up to two 64-bit register writes per
//               cycle into a 16x64 register file, owns the busy scoreboard,
//               provides bypassed read ports and a sticky end-of-sim flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_retire_wb #(
    parameter int          QDEPTH     = 2,
    parameter logic [63:0] STACK_INIT = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic        in_wa_en,
    input  logic [3:0]  in_wa_idx,
    input  logic [63:0] in_wa_data,
    input  logic        in_wb_en,
    input  logic [3:0]  in_wb_idx,
    input  logic [63:0] in_wb_data,
    input  logic        in_sim_end,
    input  logic        wb_stall,
    input  logic [3:0]  rd0_idx,
    input  logic [3:0]  rd1_idx,
    output logic [63:0] rd0_data,
    output logic [63:0] rd1_data,
    input  logic        sb_set_en,
    input  logic [3:0]  sb_set_idx,
    output logic [15:0] score_board,
    output logic        retire_valid,
    output logic [63:0] retire_pc,
    output logic [63:0] retire_count,
    output logic        sim_done
);

    localparam int          C_AW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [C_AW:0] C_DEPTH = (C_AW + 1)'(QDEPTH);

    // Queue storage (not reset: validity is tracked by the occupancy count)
    logic [63:0] r_q_pc      [QDEPTH];
    logic        r_q_wa_en   [QDEPTH];
    logic [3:0]  r_q_wa_idx  [QDEPTH];
    logic [63:0] r_q_wa_data [QDEPTH];
    logic        r_q_wb_en   [QDEPTH];
    logic [3:0]  r_q_wb_idx  [QDEPTH];
    logic [63:0] r_q_wb_data [QDEPTH];
    logic        r_q_sim_end [QDEPTH];

    logic [C_AW-1:0] r_wr_ptr;
    logic [C_AW-1:0] r_rd_ptr;
    logic [C_AW:0]   r_count;

    logic [63:0] r_regs [16];
    logic [15:0] r_score_board;
    logic        r_retire_valid;
    logic [63:0] r_retire_pc;
    logic [63:0] r_retire_count;
    logic        r_sim_done;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_wa_act;
    logic        w_wb_act;
    logic [15:0] w_sb_next;

    // Handshake and commit qualification; ready depends on registered state only
    assign w_full   = (r_count == C_DEPTH);
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full && !r_sim_done;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_empty && !wb_stall && !r_sim_done;

    // An end-of-simulation entry suppresses its register writes
    assign w_wa_act = w_pop && r_q_wa_en[r_rd_ptr] && !r_q_sim_end[r_rd_ptr];
    assign w_wb_act = w_pop && r_q_wb_en[r_rd_ptr] && !r_q_sim_end[r_rd_ptr];

    // Write accepted entries into the tail slot
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]      <= in_pc;
            r_q_wa_en[r_wr_ptr]   <= in_wa_en;
            r_q_wa_idx[r_wr_ptr]  <= in_wa_idx;
            r_q_wa_data[r_wr_ptr] <= in_wa_data;
            r_q_wb_en[r_wr_ptr]   <= in_wb_en;
            r_q_wb_idx[r_wr_ptr]  <= in_wb_idx;
            r_q_wb_data[r_wr_ptr] <= in_wb_data;
            r_q_sim_end[r_wr_ptr] <= in_sim_end;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at QDEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Architectural register file; port B is written last so it wins a tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= (i == 4) ? STACK_INIT : 64'h0;
            end
        end else begin
            if (w_wa_act) r_regs[r_q_wa_idx[r_rd_ptr]] <= r_q_wa_data[r_rd_ptr];
            if (w_wb_act) r_regs[r_q_wb_idx[r_rd_ptr]] <= r_q_wb_data[r_rd_ptr];
        end
    end

    // Scoreboard next state: commit clears first, then a decode set overrides
    always_comb begin
        w_sb_next = r_score_board;
        if (w_wa_act) w_sb_next[r_q_wa_idx[r_rd_ptr]] = 1'b0;
        if (w_wb_act) w_sb_next[r_q_wb_idx[r_rd_ptr]] = 1'b0;
        if (sb_set_en) w_sb_next[sb_set_idx] = 1'b1;
    end

    // Scoreboard, retire reporting and the sticky end flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_score_board  <= '0;
            r_retire_valid <= 1'b0;
            r_retire_pc    <= '0;
            r_retire_count <= '0;
            r_sim_done     <= 1'b0;
        end else begin
            r_score_board  <= w_sb_next;
            r_retire_valid <= w_pop;
            if (w_pop) begin
                r_retire_pc    <= r_q_pc[r_rd_ptr];
                r_retire_count <= r_retire_count + 64'd1;
                if (r_q_sim_end[r_rd_ptr]) r_sim_done <= 1'b1;
            end
        end
    end

    // Read ports with bypass from the committing head: port B, then A, then array
    always_comb begin
        rd0_data = r_regs[rd0_idx];
        rd1_data = r_regs[rd1_idx];
        if (w_wa_act && (r_q_wa_idx[r_rd_ptr] == rd0_idx)) rd0_data = r_q_wa_data[r_rd_ptr];
        if (w_wb_act && (r_q_wb_idx[r_rd_ptr] == rd0_idx)) rd0_data = r_q_wb_data[r_rd_ptr];
        if (w_wa_act && (r_q_wa_idx[r_rd_ptr] == rd1_idx)) rd1_data = r_q_wa_data[r_rd_ptr];
        if (w_wb_act && (r_q_wb_idx[r_rd_ptr] == rd1_idx)) rd1_data = r_q_wb_data[r_rd_ptr];
    end

    assign score_board  = r_score_board;
    assign retire_valid = r_retire_valid;
    assign retire_pc    = r_retire_pc;
    assign retire_count = r_retire_count;
    assign sim_done     = r_sim_done;

endmodule
`default_nettype wire

// File: tb/tb_mod_retire_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_retire_wb
// Description : Directed, table-driven self-checking bench for mod_retire_wb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_retire_wb;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic        in_wa_en;
    logic [3:0]  in_wa_idx;
    logic [63:0] in_wa_data;
    logic        in_wb_en;
    logic [3:0]  in_wb_idx;
    logic [63:0] in_wb_data;
    logic        in_sim_end;
    logic        wb_stall;
    logic [3:0]  rd0_idx;
    logic [3:0]  rd1_idx;
    logic [63:0] rd0_data;
    logic [63:0] rd1_data;
    logic        sb_set_en;
    logic [3:0]  sb_set_idx;
    logic [15:0] score_board;
    logic        retire_valid;
    logic [63:0] retire_pc;
    logic [63:0] retire_count;
    logic        sim_done;

    int errors = 0;
    int checks = 0;

    mod_retire_wb #(.QDEPTH(2), .STACK_INIT(64'h7FF0)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_wa_en(in_wa_en), .in_wa_idx(in_wa_idx), .in_wa_data(in_wa_data),
        .in_wb_en(in_wb_en), .in_wb_idx(in_wb_idx), .in_wb_data(in_wb_data),
        .in_sim_end(in_sim_end), .wb_stall(wb_stall),
        .rd0_idx(rd0_idx), .rd1_idx(rd1_idx), .rd0_data(rd0_data), .rd1_data(rd1_data),
        .sb_set_en(sb_set_en), .sb_set_idx(sb_set_idx), .score_board(score_board),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_count(retire_count), .sim_done(sim_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [63:0] pc;
        logic        wa_en;
        logic [3:0]  wa_idx;
        logic [63:0] wa_data;
        logic        wb_en;
        logic [3:0]  wb_idx;
        logic [63:0] wb_data;
        logic        sb_en;
        logic [3:0]  sb_idx;
        logic [3:0]  r0;
        logic [3:0]  r1;
        logic [63:0] e_rd0;
        logic [63:0] e_rd1;
        logic [15:0] e_sb;
        logic [63:0] e_cnt;
        logic        e_rv;
        logic        e_ready;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_pc      = '0;
        in_wa_en   = 1'b0;
        in_wa_idx  = '0;
        in_wa_data = '0;
        in_wb_en   = 1'b0;
        in_wb_idx  = '0;
        in_wb_data = '0;
        in_sim_end = 1'b0;
        sb_set_en  = 1'b0;
        sb_set_idx = '0;
    endtask

    task automatic offer(input logic [63:0] pc, input logic [3:0] idx,
                         input logic [63:0] data, input logic send_end);
        in_valid   = 1'b1;
        in_pc      = pc;
        in_wa_en   = 1'b1;
        in_wa_idx  = idx;
        in_wa_data = data;
        in_sim_end = send_end;
    endtask

    initial begin
        // vecs: valid pc wa_en wa_idx wa_data wb_en wb_idx wb_data sb_en sb_idx r0 r1 | rd0 rd1 sb cnt rv ready
        vecs[0] = '{1'b0, 64'h0,  1'b0, 4'd0, 64'h0,    1'b0, 4'd0, 64'h0,    1'b1, 4'd3, 4'd3, 4'd4,
                    64'h0,    64'h7FF0, 16'h0008, 64'd0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 64'h10, 1'b1, 4'd3, 64'h55,   1'b0, 4'd0, 64'h0,    1'b0, 4'd0, 4'd3, 4'd4,
                    64'h55,   64'h7FF0, 16'h0008, 64'd0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 64'h0,  1'b0, 4'd0, 64'h0,    1'b0, 4'd0, 64'h0,    1'b0, 4'd0, 4'd3, 4'd4,
                    64'h55,   64'h7FF0, 16'h0000, 64'd1, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 64'h14, 1'b1, 4'd0, 64'h1,    1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd2, 4'd2, 4'd0,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 16'h0004, 64'd1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 64'h0,  1'b0, 4'd0, 64'h0,    1'b0, 4'd0, 64'h0,    1'b0, 4'd0, 4'd0, 4'd2,
                    64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 64'd2, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 64'h18, 1'b1, 4'd5, 64'hAAAA, 1'b1, 4'd5, 64'hBBBB, 1'b0, 4'd0, 4'd5, 4'd5,
                    64'hBBBB, 64'hBBBB, 16'h0000, 64'd2, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 64'h0,  1'b0, 4'd0, 64'h0,    1'b0, 4'd0, 64'h0,    1'b0, 4'd0, 4'd5, 4'd3,
                    64'hBBBB, 64'h55, 16'h0000, 64'd3, 1'b1, 1'b1};

        idle();
        wb_stall = 1'b0;
        rd0_idx  = 4'd4;
        rd1_idx  = 4'd9;
        reset    = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_reg4", rd0_data, 64'h7FF0);
        check("rst_reg9", rd1_data, 64'h0);
        check("rst_ready", {63'h0, in_ready}, 64'h1);
        check("rst_sb", {48'h0, score_board}, 64'h0);
        check("rst_count", retire_count, 64'h0);
        check("rst_rv", {63'h0, retire_valid}, 64'h0);
        check("rst_done", {63'h0, sim_done}, 64'h0);
        for (int i = 0; i < 16; i++) begin
            if (i != 4) begin
                rd0_idx = 4'(i);
                #1;
                check("rst_regs", rd0_data, 64'h0);
            end
        end

        // Table: each vector is driven for one edge, then checked after it
        for (int v = 0; v < 7; v++) begin
            in_valid   = vecs[v].valid;
            in_pc      = vecs[v].pc;
            in_wa_en   = vecs[v].wa_en;
            in_wa_idx  = vecs[v].wa_idx;
            in_wa_data = vecs[v].wa_data;
            in_wb_en   = vecs[v].wb_en;
            in_wb_idx  = vecs[v].wb_idx;
            in_wb_data = vecs[v].wb_data;
            sb_set_en  = vecs[v].sb_en;
            sb_set_idx = vecs[v].sb_idx;
            tick();
            idle();
            rd0_idx = vecs[v].r0;
            rd1_idx = vecs[v].r1;
            #1;
            check($sformatf("vec%0d_rd0", v), rd0_data, vecs[v].e_rd0);
            check($sformatf("vec%0d_rd1", v), rd1_data, vecs[v].e_rd1);
            check($sformatf("vec%0d_sb", v), {48'h0, score_board}, {48'h0, vecs[v].e_sb});
            check($sformatf("vec%0d_cnt", v), retire_count, vecs[v].e_cnt);
            check($sformatf("vec%0d_rv", v), {63'h0, retire_valid}, {63'h0, vecs[v].e_rv});
            check($sformatf("vec%0d_ready", v), {63'h0, in_ready}, {63'h0, vecs[v].e_ready});
        end
        check("tbl_retire_pc", retire_pc, 64'h18);

        // Stall: fill the queue, third offer must be refused
        wb_stall = 1'b1;
        offer(64'h100, 4'd6, 64'h61, 1'b0);
        sb_set_en  = 1'b1;
        sb_set_idx = 4'd7;
        tick();
        sb_set_en = 1'b0;
        check("stall_sb7", {48'h0, score_board}, 64'h0080);
        check("stall_ready1", {63'h0, in_ready}, 64'h1);
        offer(64'h104, 4'd7, 64'h71, 1'b0);
        tick();
        check("stall_ready_full", {63'h0, in_ready}, 64'h0);
        offer(64'h108, 4'd8, 64'h81, 1'b0);
        tick();
        check("stall_ready_held", {63'h0, in_ready}, 64'h0);
        check("stall_cnt", retire_count, 64'd3);
        check("stall_rv", {63'h0, retire_valid}, 64'h0);
        rd0_idx = 4'd6;
        #1;
        check("stall_no_bypass", rd0_data, 64'h0);

        // Release: in-order commits, one per cycle, with bypass
        idle();
        wb_stall = 1'b0;
        #1;
        check("rel_bypass6", rd0_data, 64'h61);
        tick();
        check("rel_pc1", retire_pc, 64'h100);
        check("rel_cnt1", retire_count, 64'd4);
        check("rel_rv1", {63'h0, retire_valid}, 64'h1);
        rd0_idx    = 4'd7;
        sb_set_en  = 1'b1;
        sb_set_idx = 4'd7;
        #1;
        check("rel_bypass7", rd0_data, 64'h71);
        tick();
        sb_set_en = 1'b0;
        check("rel_pc2", retire_pc, 64'h104);
        check("rel_cnt2", retire_count, 64'd5);
        check("set_wins_sb7", {48'h0, score_board}, 64'h0080);
        tick();
        rd0_idx = 4'd8;
        rd1_idx = 4'd6;
        #1;
        check("rel_rv_idle", {63'h0, retire_valid}, 64'h0);
        check("rel_cnt_idle", retire_count, 64'd5);
        check("rel_reg8", rd0_data, 64'h0);
        check("rel_reg6", rd1_data, 64'h61);

        // sim_end entry followed by a normal entry
        offer(64'h200, 4'd9, 64'hDEAD, 1'b1);
        tick();
        offer(64'h204, 4'd10, 64'h77, 1'b0);
        tick();
        idle();
        rd0_idx = 4'd9;
        rd1_idx = 4'd10;
        #1;
        check("end_done", {63'h0, sim_done}, 64'h1);
        check("end_pc", retire_pc, 64'h200);
        check("end_cnt", retire_count, 64'd6);
        check("end_ready", {63'h0, in_ready}, 64'h0);
        check("end_reg9", rd0_data, 64'h0);
        repeat (3) tick();
        check("end_done_sticky", {63'h0, sim_done}, 64'h1);
        check("end_cnt_held", retire_count, 64'd6);
        check("end_reg10", rd1_data, 64'h0);
        check("end_rv", {63'h0, retire_valid}, 64'h0);

        // Asynchronous reset mid-stall, between clock edges
        wb_stall = 1'b1;
        rd0_idx  = 4'd4;
        rd1_idx  = 4'd6;
        #2;
        reset = 1'b1;
        #1;
        check("arst_done", {63'h0, sim_done}, 64'h0);
        check("arst_cnt", retire_count, 64'h0);
        check("arst_pc", retire_pc, 64'h0);
        check("arst_sb", {48'h0, score_board}, 64'h0);
        check("arst_reg4", rd0_data, 64'h7FF0);
        check("arst_reg6", rd1_data, 64'h0);
        #1;
        reset    = 1'b0;
        wb_stall = 1'b0;
        #1;
        check("arst_ready", {63'h0, in_ready}, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
